deck_turn_ctrl: RTL and testbench

Parametrised turn and deck-draw controller for the multi-board card game; the next generation of the game-control FSM. It runs the initial deal across `NUM_PLAYER` boards and rotates turns on `STATE_TURN` messages. On the local player's turn it picks a random available card from the shared deck and drives DECK_DRAW / STATE_TURN messages to the interboard link and memory. Rule checking, table moves and display selection stay in the surrounding game-control logic.

---
 rtl/deck_turn_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_deck_turn_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_turn_ctrl.sv
// Turn rotation and deck-draw controller: deals INIT_DRAW cards per board, passes turns on
// STATE_TURN, and draws a random available card (1..CARD_NUM scan cycles; sends wait on ctrl_ready).
module deck_turn_ctrl #(
   parameter int          PLAYER     = 0,
   parameter int          NUM_PLAYER = 2,
   parameter int          CARD_NUM   = 106,
   parameter int          CW         = 7,
   parameter int          INIT_DRAW  = 14,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                interboard_rst,
   input  logic                start_game,
   input  logic                done_and_next,
   input  logic                draw_and_next,
   input  logic                rule_valid,
   input  logic                interboard_en,
   input  logic [3:0]          interboard_msg_type,
   input  logic                ctrl_ready,
   input  logic [CARD_NUM-1:0] available_card,
   output logic                my_turn,
   output logic                transmit,
   output logic                can_done,
   output logic                can_draw,
   output logic                deck_empty,
   output logic [1:0]          cur_player,
   output logic                ctrl_en,
   output logic [3:0]          ctrl_msg_type,
   output logic [CW-1:0]       ctrl_card
);

   localparam logic [3:0]     MSG_DRAW = 4'd5;
   localparam logic [3:0]     MSG_TURN = 4'd6;
   localparam int             DCW      = $clog2(INIT_DRAW + 1);
   localparam logic [DCW-1:0] DEAL_M1  = DCW'(INIT_DRAW - 1);
   localparam logic [CW-1:0]  LAST_IDX = CW'(CARD_NUM - 1);
   localparam logic [CW:0]    CARD_W   = (CW + 1)'(CARD_NUM);
   localparam logic [1:0]     ME       = 2'(PLAYER);
   localparam logic [1:0]     LAST_PL  = 2'(NUM_PLAYER - 1);
   localparam bit             IS_P0    = (PLAYER == 0);

   typedef enum logic [3:0] {
      IDLE, DEAL_WAIT, PICK, SCAN, SEND_DRAW, WAIT_CLR, SEND_TURN, WAIT_TURN, MY_TURN
   } state_t;

   state_t         state, state_n;
   logic [1:0]     player_n;
   logic [DCW-1:0] deal_cnt, deal_cnt_n;
   logic           dealing, dealing_n;
   logic           deck_empty_n;
   logic           ctrl_en_n;
   logic [3:0]     msg_n;
   logic [CW-1:0]  card_n;
   logic [CW-1:0]  idx, idx_n;
   logic [CW-1:0]  scan_cnt, scan_cnt_n;
   logic [15:0]    lfsr, lfsr_n;

   logic           turn_msg;
   logic           wrap;
   logic [1:0]     nxt_player;
   logic [CW-1:0]  raw_idx;
   logic [CW-1:0]  pick_idx;

   assign turn_msg   = interboard_en && (interboard_msg_type == MSG_TURN);
   assign wrap       = (cur_player == LAST_PL);
   assign nxt_player = wrap ? 2'd0 : cur_player + 2'd1;

   // CARD_NUM > 2^(CW-1), so a single conditional subtract folds any raw value into range
   assign raw_idx  = lfsr[CW-1:0];
   assign pick_idx = ({1'b0, raw_idx} >= CARD_W) ? raw_idx - CARD_W[CW-1:0] : raw_idx;

   assign my_turn  = (state != IDLE) && (cur_player == ME);
   assign transmit = my_turn;
   assign can_done = (state == MY_TURN) && rule_valid;
   assign can_draw = (state == MY_TURN) && !deck_empty;

   always_comb begin
      state_n      = state;
      player_n     = cur_player;
      deal_cnt_n   = deal_cnt;
      dealing_n    = dealing;
      deck_empty_n = deck_empty;
      ctrl_en_n    = 1'b0;
      msg_n        = ctrl_msg_type;
      card_n       = ctrl_card;
      idx_n        = idx;
      scan_cnt_n   = scan_cnt;
      lfsr_n       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      case (state)
         IDLE: begin
            if (start_game) begin
               dealing_n  = 1'b1;
               deal_cnt_n = '0;
               state_n    = IS_P0 ? PICK : DEAL_WAIT;
            end
         end
         DEAL_WAIT, WAIT_TURN: begin
            if (turn_msg) begin
               player_n = nxt_player;
               if (wrap && dealing)
                  dealing_n = 1'b0;
               if (nxt_player == ME)
                  state_n = dealing_n ? PICK : MY_TURN;
            end
         end
         PICK: begin
            idx_n      = pick_idx;
            scan_cnt_n = '0;
            state_n    = SCAN;
         end
         SCAN: begin
            if (available_card[idx]) begin
               card_n       = idx;
               deck_empty_n = 1'b0;
               state_n      = SEND_DRAW;
            end else if (scan_cnt == LAST_IDX) begin
               deck_empty_n = 1'b1;
               state_n      = SEND_TURN;
            end else begin
               idx_n      = (idx == LAST_IDX) ? '0 : idx + CW'(1);
               scan_cnt_n = scan_cnt + CW'(1);
            end
         end
         SEND_DRAW: begin
            if (ctrl_ready) begin
               ctrl_en_n = 1'b1;
               msg_n     = MSG_DRAW;
               state_n   = WAIT_CLR;
            end
         end
         WAIT_CLR: begin
            // memory acknowledges the draw by dropping the card from the deck
            if (!available_card[ctrl_card]) begin
               if (dealing) begin
                  deal_cnt_n = deal_cnt + DCW'(1);
                  state_n    = (deal_cnt == DEAL_M1) ? SEND_TURN : PICK;
               end else begin
                  state_n = SEND_TURN;
               end
            end
         end
         SEND_TURN: begin
            if (ctrl_ready) begin
               ctrl_en_n  = 1'b1;
               msg_n      = MSG_TURN;
               player_n   = nxt_player;
               deal_cnt_n = '0;
               state_n    = WAIT_TURN;
               if (wrap && dealing) begin
                  dealing_n = 1'b0;
                  if (IS_P0)
                     state_n = MY_TURN;
               end
            end
         end
         MY_TURN: begin
            if (done_and_next && rule_valid)
               state_n = SEND_TURN;
            else if (draw_and_next && !deck_empty)
               state_n = PICK;
         end
         default: state_n = IDLE;
      endcase

      if (interboard_rst) begin
         state_n      = IDLE;
         player_n     = '0;
         deal_cnt_n   = '0;
         dealing_n    = 1'b0;
         deck_empty_n = 1'b0;
         ctrl_en_n    = 1'b0;
         msg_n        = '0;
         card_n       = '0;
         idx_n        = '0;
         scan_cnt_n   = '0;
         lfsr_n       = LFSR_SEED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cur_player    <= '0;
         deal_cnt      <= '0;
         dealing       <= 1'b0;
         deck_empty    <= 1'b0;
         ctrl_en       <= 1'b0;
         ctrl_msg_type <= '0;
         ctrl_card     <= '0;
         idx           <= '0;
         scan_cnt      <= '0;
         lfsr          <= LFSR_SEED;
      end else begin
         state         <= state_n;
         cur_player    <= player_n;
         deal_cnt      <= deal_cnt_n;
         dealing       <= dealing_n;
         deck_empty    <= deck_empty_n;
         ctrl_en       <= ctrl_en_n;
         ctrl_msg_type <= msg_n;
         ctrl_card     <= card_n;
         idx           <= idx_n;
         scan_cnt      <= scan_cnt_n;
         lfsr          <= lfsr_n;
      end
   end

endmodule

// File: tb/tb_deck_turn_ctrl.sv
// Scoreboard bench for deck_turn_ctrl: expected link messages are queued per action and
// popped by a monitor that also plays the card memory.
module tb_deck_turn_ctrl;

   localparam int          PLAYER     = 0;
   localparam int          NUM_PLAYER = 2;
   localparam int          CARD_NUM   = 106;
   localparam int          CW         = 7;
   localparam int          INIT_DRAW  = 14;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic                clk = 1'b0;
   logic                rst, interboard_rst, start_game, done_and_next, draw_and_next;
   logic                rule_valid, interboard_en;
   logic [3:0]          interboard_msg_type;
   logic                ctrl_ready;
   logic [CARD_NUM-1:0] deck;
   logic                my_turn, transmit, can_done, can_draw, deck_empty;
   logic [1:0]          cur_player;
   logic                ctrl_en;
   logic [3:0]          ctrl_msg_type;
   logic [CW-1:0]       ctrl_card;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   int total5  = 0;
   int deal_id = 1;
   int seen_deal[CARD_NUM];
   int deck_req_id = 0;
   logic [CARD_NUM-1:0] deck_req_val;
   logic hold_ready  = 1'b0;
   logic force_ready = 1'b0;
   logic rdy_rand    = 1'b1;
   logic m_deck_empty;
   logic [15:0] m_lfsr;

   deck_turn_ctrl #(
      .PLAYER(PLAYER), .NUM_PLAYER(NUM_PLAYER), .CARD_NUM(CARD_NUM), .CW(CW),
      .INIT_DRAW(INIT_DRAW), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .start_game(start_game),
      .done_and_next(done_and_next), .draw_and_next(draw_and_next), .rule_valid(rule_valid),
      .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
      .ctrl_ready(ctrl_ready), .available_card(deck), .my_turn(my_turn), .transmit(transmit),
      .can_done(can_done), .can_draw(can_draw), .deck_empty(deck_empty),
      .cur_player(cur_player), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
      .ctrl_card(ctrl_card)
   );

   always #5 clk = ~clk;

   assign ctrl_ready = force_ready | (rdy_rand & ~hold_ready);

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Reference LFSR sequence: seeded in reset, one step per clock otherwise
   always @(posedge clk or posedge rst) begin
      if (rst || interboard_rst) m_lfsr <= SEED;
      else                       m_lfsr <= lfsr_step(m_lfsr);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_msg6();
      interboard_en = 1'b1; interboard_msg_type = 4'd6;
      tick(1);
      interboard_en = 1'b0; interboard_msg_type = 4'd0;
   endtask

   task automatic act(input logic d, input logic w, input logic rv);
      rule_valid = rv; done_and_next = d; draw_and_next = w;
      tick(1);
      done_and_next = 1'b0; draw_and_next = 1'b0;
   endtask

   task automatic set_deck(input logic [CARD_NUM-1:0] v);
      deal_id++;
      deck_req_val = v;
      deck_req_id++;
      tick(2);
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d messages outstanding after %0d cycles, expected 0",
                  name, exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic push_deal();
      for (int i = 0; i < INIT_DRAW; i++) exp_q.push_back(5);
      exp_q.push_back(6);
   endtask

   // Random ready pattern for the link
   initial begin
      forever begin
         @(negedge clk);
         rdy_rand = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor and card memory: pops one expectation per ctrl_en, clears the card 1..3 cycles later
   initial begin : monitor
      int clr_card, clr_wait, ack_id, e;
      clr_card = 0; clr_wait = 0; ack_id = 0;
      deck = '1;
      forever begin
         @(negedge clk);
         if (deck_req_id != ack_id) begin
            deck = deck_req_val; ack_id = deck_req_id; clr_wait = 0;
         end
         if (clr_wait > 0) begin
            clr_wait--;
            if (clr_wait == 0) deck[clr_card] = 1'b0;
         end
         if (ctrl_en) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_msg: got msg %0d card %0d, expected no message",
                        ctrl_msg_type, ctrl_card);
            end else begin
               e = exp_q.pop_front();
               check("msg_type", ctrl_msg_type, e);
               if (ctrl_msg_type == 4'd5) begin
                  total5++;
                  check("card_in_range", int'(ctrl_card) < CARD_NUM, 1);
                  if (int'(ctrl_card) < CARD_NUM) begin
                     check("card_available", deck[ctrl_card], 1);
                     check("card_repeated", seen_deal[ctrl_card] == deal_id, 0);
                     seen_deal[ctrl_card] = deal_id;
                     clr_card = int'(ctrl_card);
                     clr_wait = $urandom_range(1, 3);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : seq
      int base, k, lat;
      logic d, w, rv, passes;
      logic [15:0] nx;
      logic [CARD_NUM-1:0] mask;

      rst = 1'b1; interboard_rst = 1'b0; start_game = 1'b0; done_and_next = 1'b0;
      draw_and_next = 1'b0; rule_valid = 1'b0; interboard_en = 1'b0;
      interboard_msg_type = 4'd0; m_deck_empty = 1'b0;
      tick(3);
      check("rst_my_turn", my_turn, 0);
      check("rst_cur_player", cur_player, 0);
      check("rst_ctrl_en", ctrl_en, 0);
      check("rst_msg_type", ctrl_msg_type, 0);
      check("rst_ctrl_card", ctrl_card, 0);
      check("rst_deck_empty", deck_empty, 0);
      rst = 1'b0;
      tick(2);

      // Initial deal from a full deck
      base = total5;
      push_deal();
      start_game = 1'b1; tick(1); start_game = 1'b0;
      drain("deal", 3000);
      tick(3);
      check("deal_cards", total5 - base, INIT_DRAW);
      check("deal_cur_player", cur_player, 1);
      check("deal_my_turn", my_turn, 0);
      send_msg6(); tick(1);
      check("turn_my_turn", my_turn, 1);
      check("turn_transmit", transmit, 1);
      check("turn_cur_player", cur_player, 0);
      check("turn_can_draw", can_draw, 1);

      // Done beats draw when rule_valid
      exp_q.push_back(6);
      act(1'b1, 1'b1, 1'b1);
      drain("prio_done", 300); tick(3);
      check("prio_done_passed", my_turn, 0);
      send_msg6(); tick(1);
      // Without rule_valid the draw wins
      exp_q.push_back(5); exp_q.push_back(6);
      act(1'b1, 1'b1, 1'b0);
      drain("prio_draw", 600); tick(3);
      check("prio_draw_passed", my_turn, 0);
      send_msg6(); tick(1);
      act(1'b1, 1'b0, 1'b0); tick(8);
      check("done_ignored", my_turn, 1);
      check("can_done_low", can_done, 0);

      // Random play against a set-level deck model
      for (int it = 0; it < 16; it++) begin
         if ($countones(deck) > 60 && $urandom_range(0, 2) == 0) begin
            for (int i = 0; i < CARD_NUM; i++) mask[i] = 1'($urandom_range(0, 1));
            set_deck(deck & mask);
         end
         d = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1));
         rv = 1'($urandom_range(0, 1));
         rule_valid = rv; tick(1);
         check("rand_can_done", can_done, rv);
         check("rand_can_draw", can_draw, !m_deck_empty);
         passes = 1'b0;
         if (d && rv) begin
            exp_q.push_back(6); passes = 1'b1;
         end else if (w && !m_deck_empty) begin
            passes = 1'b1;
            if ($countones(deck) == 0) begin
               exp_q.push_back(6); m_deck_empty = 1'b1;
            end else begin
               exp_q.push_back(5); exp_q.push_back(6);
            end
         end
         act(d, w, rv);
         if (passes) begin
            drain("rand_action", 600); tick(3);
            check("rand_passed", my_turn, 0);
            send_msg6(); tick(1);
         end else begin
            if ($urandom_range(0, 1) == 1) send_msg6();
            tick(8);
         end
         check("rand_my_turn", my_turn, 1);
      end

      // interboard_rst in the middle of a deal, then a full redeal
      interboard_rst = 1'b1; tick(1); interboard_rst = 1'b0;
      exp_q.delete(); m_deck_empty = 1'b0;
      set_deck('1);
      base = total5;
      push_deal();
      start_game = 1'b1; tick(1); start_game = 1'b0;
      k = 0;
      while (total5 - base < 7 && k < 2000) begin tick(1); k++; end
      hold_ready = 1'b1;
      check("partial_deal_cards", total5 - base, 7);
      tick(6);
      interboard_rst = 1'b1; tick(1); interboard_rst = 1'b0;
      exp_q.delete();
      hold_ready = 1'b0;
      tick(1);
      check("ibrst_cur_player", cur_player, 0);
      check("ibrst_my_turn", my_turn, 0);
      check("ibrst_ctrl_en", ctrl_en, 0);
      check("ibrst_msg_type", ctrl_msg_type, 0);
      set_deck('1);
      base = total5;
      push_deal();
      start_game = 1'b1; tick(1); start_game = 1'b0;
      drain("redeal", 3000); tick(3);
      check("redeal_cards", total5 - base, INIT_DRAW);
      check("redeal_cur_player", cur_player, 1);
      send_msg6(); tick(1);
      check("redeal_my_turn", my_turn, 1);

      // Pick lands on the last index, only card 0 left: scan wraps
      force_ready = 1'b1;
      set_deck(CARD_NUM'(1));
      k = 0;
      nx = lfsr_step(m_lfsr);
      while (nx[CW-1:0] != CW'(CARD_NUM - 1) && k < 5000) begin
         tick(1); k++; nx = lfsr_step(m_lfsr);
      end
      exp_q.push_back(5); exp_q.push_back(6);
      draw_and_next = 1'b1;
      lat = 0;
      do begin
         tick(1); draw_and_next = 1'b0; lat++;
      end while (!(ctrl_en && ctrl_msg_type == 4'd5) && lat < 300);
      check("wrap_latency_ok", lat <= 5, 1);
      check("wrap_card", ctrl_card, 0);
      drain("wrap", 300); tick(3);
      send_msg6(); tick(1);

      // Empty deck: full scan, then a turn message only
      check("empty_pre_deck", $countones(deck), 0);
      exp_q.push_back(6); m_deck_empty = 1'b1;
      draw_and_next = 1'b1;
      lat = 0;
      do begin
         tick(1); draw_and_next = 1'b0; lat++;
      end while (!ctrl_en && lat < 400);
      check("empty_latency", lat, 3 + CARD_NUM);
      check("empty_flag", deck_empty, 1);
      drain("empty", 300); tick(3);
      send_msg6(); tick(1);
      check("empty_my_turn", my_turn, 1);
      check("empty_can_draw", can_draw, 0);
      act(1'b0, 1'b1, 1'b0); tick(10);
      check("empty_draw_ignored", my_turn, 1);
      force_ready = 1'b0;

      // Asynchronous reset lands between clock edges
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_my_turn", my_turn, 0);
      check("arst_cur_player", cur_player, 0);
      check("arst_deck_empty", deck_empty, 0);
      check("arst_ctrl_en", ctrl_en, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
